// File: rtl/bp_be_nonsynth_resp_collector.sv
// Per-channel response FIFOs with optional LFSR-gated drain, plus a
// watchdog and sticky pass/fail aggregation for trace-replay benches.
module bp_be_nonsynth_resp_collector #(
    parameter int          num_caches_p    = 1,
    parameter int          width_p         = 64,
    parameter int          els_p           = 8,
    parameter int          random_yumi_p   = 0,
    parameter int          yumi_min_delay_p = 0,
    parameter int          yumi_max_delay_p = 15,
    parameter logic [15:0] seed_p          = 16'hACE1,
    parameter int          timeout_width_p = 16,
    localparam int         cw_lp = $clog2(els_p + 1)
) (
    input  logic                              clk_i,
    input  logic                              reset_n_i,
    input  logic [num_caches_p-1:0]           v_i,
    input  logic [num_caches_p*width_p-1:0]   data_i,
    output logic [num_caches_p-1:0]           ready_o,
    output logic [num_caches_p-1:0]           v_o,
    output logic [num_caches_p*width_p-1:0]   data_o,
    input  logic [num_caches_p-1:0]           ready_i,
    input  logic [num_caches_p-1:0]           done_i,
    output logic [num_caches_p*cw_lp-1:0]     count_o,
    output logic [num_caches_p-1:0]           overflow_o,
    output logic                              pass_o,
    output logic                              fail_o
);

    localparam int pw_lp   = $clog2(els_p);
    localparam int span_lp = yumi_max_delay_p - yumi_min_delay_p + 1;

    typedef enum logic [1:0] {IDLE_S, WAIT_S, OFFER_S} state_e;

    logic [num_caches_p-1:0]    enq_v;
    logic [num_caches_p-1:0]    deq_v;
    logic [num_caches_p-1:0]    busy_n_v;
    logic [timeout_width_p-1:0] wd_q;
    logic                       pass_q;
    logic                       fail_q;
    logic                       fail_cond;
    logic                       pass_cond;

    for (genvar i = 0; i < num_caches_p; i++) begin : ch
        localparam logic [15:0] raw_seed_lp = seed_p ^ 16'(i);
        localparam logic [15:0] seed_lp =
            (raw_seed_lp == 16'd0) ? 16'd1 : raw_seed_lp;

        logic [width_p-1:0] mem_q [els_p];
        logic [pw_lp-1:0]   wptr_q;
        logic [pw_lp-1:0]   rptr_q;
        logic [cw_lp-1:0]   cnt_q;
        logic [cw_lp-1:0]   cnt_n;
        logic               ovf_q;
        logic               rdy;
        logic               vo;
        logic               enq;
        logic               deq;

        state_e      state_q;
        state_e      state_n;
        logic [15:0] lfsr_q;
        logic [15:0] lfsr_n;
        logic [15:0] dly_q;
        logic [15:0] dly_n;
        logic [15:0] dly_new;
        logic        load;

        assign rdy   = (cnt_q != cw_lp'(els_p));
        assign enq   = v_i[i] & rdy;
        assign deq   = vo & ready_i[i];
        assign cnt_n = cnt_q + cw_lp'(enq) - cw_lp'(deq);

        assign enq_v[i]      = enq;
        assign deq_v[i]      = deq;
        assign busy_n_v[i]   = (cnt_n != '0);
        assign ready_o[i]    = rdy;
        assign v_o[i]        = vo;
        assign overflow_o[i] = ovf_q;
        assign data_o[i*width_p +: width_p] = mem_q[rptr_q];
        assign count_o[i*cw_lp +: cw_lp]    = cnt_q;

        always_ff @(posedge clk_i) begin
            if (enq) mem_q[wptr_q] <= data_i[i*width_p +: width_p];
        end

        always_ff @(posedge clk_i) begin
            if (!reset_n_i) begin
                wptr_q <= '0;
                rptr_q <= '0;
                cnt_q  <= '0;
                ovf_q  <= 1'b0;
            end else begin
                if (enq) wptr_q <= wptr_q + 1'b1;
                if (deq) rptr_q <= rptr_q + 1'b1;
                cnt_q <= cnt_n;
                if (v_i[i] & ~rdy) ovf_q <= 1'b1;
            end
        end

        // Drain gate: delay drawn from the LFSR each time a head is armed
        assign dly_new = 16'(32'(yumi_min_delay_p)
                       + (32'(lfsr_q) % 32'(span_lp)));

        always_ff @(posedge clk_i) begin
            if (!reset_n_i) begin
                state_q <= IDLE_S;
                lfsr_q  <= seed_lp;
                dly_q   <= '0;
            end else begin
                state_q <= state_n;
                lfsr_q  <= lfsr_n;
                dly_q   <= dly_n;
            end
        end

        always_comb begin
            state_n = state_q;
            dly_n   = dly_q;
            lfsr_n  = lfsr_q;
            load    = 1'b0;
            unique case (state_q)
                IDLE_S: begin
                    if (cnt_q != '0) load = 1'b1;
                end
                WAIT_S: begin
                    if (dly_q <= 16'd1) state_n = OFFER_S;
                    else dly_n = dly_q - 16'd1;
                end
                OFFER_S: begin
                    if (ready_i[i]) begin
                        if (cnt_n != '0) load = 1'b1;
                        else state_n = IDLE_S;
                    end
                end
                default: state_n = IDLE_S;
            endcase
            if (load) begin
                lfsr_n  = {lfsr_q[14:0],
                           lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
                dly_n   = dly_new;
                state_n = (dly_new == 16'd0) ? OFFER_S : WAIT_S;
            end
        end

        always_comb begin
            vo = (random_yumi_p != 0) ? (state_q == OFFER_S)
                                      : (cnt_q != '0);
        end
    end

    assign fail_cond = (&wd_q) | (|overflow_o);
    assign pass_cond = (&done_i) & ~(|busy_n_v) & ~fail_q & ~fail_cond;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            wd_q   <= '0;
            pass_q <= 1'b0;
            fail_q <= 1'b0;
        end else begin
            if ((|enq_v) | (|deq_v)) wd_q <= '0;
            else if (!(pass_q | fail_q)) wd_q <= wd_q + 1'b1;
            fail_q <= fail_q | fail_cond;
            pass_q <= pass_q | pass_cond;
        end
    end

    assign pass_o = pass_q;
    assign fail_o = fail_q;

endmodule

// File: tb/tb_bp_be_nonsynth_resp_collector.sv
// Randomized and directed checks of the response collector against a
// queue-based reference model, over three configurations.
module tb_bp_be_nonsynth_resp_collector;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // A: one channel, plain drain, short watchdog
    logic        a_v, a_rdy_o, a_vo, a_ri, a_done, a_ovf, a_pass, a_fail;
    logic [15:0] a_d, a_do;
    logic [3:0]  a_cnt;

    bp_be_nonsynth_resp_collector #(
        .num_caches_p(1), .width_p(16), .els_p(8), .random_yumi_p(0),
        .timeout_width_p(4)
    ) u_a (
        .clk_i(clk), .reset_n_i(rst_n), .v_i(a_v), .data_i(a_d),
        .ready_o(a_rdy_o), .v_o(a_vo), .data_o(a_do), .ready_i(a_ri),
        .done_i(a_done), .count_o(a_cnt), .overflow_o(a_ovf),
        .pass_o(a_pass), .fail_o(a_fail)
    );

    // B: one channel, fixed 3-cycle gate delay
    logic        b_v, b_rdy_o, b_vo, b_ri, b_done, b_ovf, b_pass, b_fail;
    logic [15:0] b_d, b_do;
    logic [3:0]  b_cnt;

    bp_be_nonsynth_resp_collector #(
        .num_caches_p(1), .width_p(16), .els_p(8), .random_yumi_p(1),
        .yumi_min_delay_p(3), .yumi_max_delay_p(3), .timeout_width_p(16)
    ) u_b (
        .clk_i(clk), .reset_n_i(rst_n), .v_i(b_v), .data_i(b_d),
        .ready_o(b_rdy_o), .v_o(b_vo), .data_o(b_do), .ready_i(b_ri),
        .done_i(b_done), .count_o(b_cnt), .overflow_o(b_ovf),
        .pass_o(b_pass), .fail_o(b_fail)
    );

    // C: two channels, random 0..15 gate delay
    logic [1:0]  c_v, c_rdy_o, c_vo, c_ri, c_done, c_ovf;
    logic        c_pass, c_fail;
    logic [31:0] c_d, c_do;
    logic [7:0]  c_cnt;

    bp_be_nonsynth_resp_collector #(
        .num_caches_p(2), .width_p(16), .els_p(8), .random_yumi_p(1),
        .yumi_min_delay_p(0), .yumi_max_delay_p(15), .timeout_width_p(16)
    ) u_c (
        .clk_i(clk), .reset_n_i(rst_n), .v_i(c_v), .data_i(c_d),
        .ready_o(c_rdy_o), .v_o(c_vo), .data_o(c_do), .ready_i(c_ri),
        .done_i(c_done), .count_o(c_cnt), .overflow_o(c_ovf),
        .pass_o(c_pass), .fail_o(c_fail)
    );

    // Reference state for A
    logic [15:0] qa[$];
    bit          m_ovf, m_fail, m_pass;
    int          m_idle;

    task automatic do_reset();
        rst_n = 1'b0;
        a_v = 0; a_d = 0; a_ri = 0; a_done = 0;
        b_v = 0; b_d = 0; b_ri = 0; b_done = 0;
        c_v = 0; c_d = 0; c_ri = 0; c_done = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        qa.delete();
        m_ovf = 0; m_fail = 0; m_pass = 0; m_idle = 0;
    endtask

    // Check A against the model, apply one cycle of stimulus, advance model
    task automatic step_a(input bit vi, input logic [15:0] d,
                          input bit rdy, input bit dn);
        int  sz;
        bit  enq, deq, fc;
        sz = qa.size();
        chk("a_count", a_cnt, sz);
        chk("a_v_o", a_vo, sz != 0);
        chk("a_ready", a_rdy_o, sz < 8);
        chk("a_ovf", a_ovf, m_ovf);
        chk("a_fail", a_fail, m_fail);
        chk("a_pass", a_pass, m_pass);
        if (sz != 0) chk("a_data", a_do, qa[0]);
        a_v = vi; a_d = d; a_ri = rdy; a_done = dn;
        @(posedge clk);
        enq = vi && sz < 8;
        deq = sz != 0 && rdy;
        fc  = m_ovf || m_idle == 15;
        m_pass = m_pass || (dn && (sz + enq - deq) == 0 && !m_fail && !fc);
        m_fail = m_fail || fc;
        if (enq || deq) m_idle = 0;
        else if (!(m_pass || m_fail)) m_idle = (m_idle + 1) % 16;
        if (vi && sz == 8) m_ovf = 1;
        if (deq) void'(qa.pop_front());
        if (enq) qa.push_back(d);
        @(negedge clk);
    endtask

    task automatic b_lat(output int lat);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (b_vo) begin
                lat = k;
                break;
            end
        end
    endtask

    logic [15:0] qc[2][$];
    int          st[2];
    bit          fr[2];
    bit          pvo[2];

    initial begin
        int lat, sent, diff;
        bit v, r;
        logic [15:0] d;

        // A: ordered pass-through
        do_reset();
        step_a(1, 16'h1, 1, 0);
        step_a(1, 16'h2, 1, 0);
        step_a(1, 16'h3, 1, 0);
        repeat (3) step_a(0, 0, 1, 0);

        // A: fill, overflow, fail blocks pass while draining
        do_reset();
        for (int i = 0; i < 8; i++) step_a(1, 16'h40 + 16'(i), 0, 0);
        step_a(1, 16'hDEAD, 0, 0);
        repeat (12) step_a(0, 0, 1, 1);

        // A: watchdog expiry with no traffic
        do_reset();
        repeat (20) step_a(0, 0, 1, 0);

        // A: sparse traffic keeps the watchdog alive
        do_reset();
        for (int i = 0; i < 60; i++) step_a(i % 10 == 0, 16'(i), 1, 0);

        // A: random traffic including overflow and done
        do_reset();
        for (int i = 0; i < 200; i++)
            step_a($urandom_range(0, 1), 16'($urandom), $urandom_range(0, 1),
                   $urandom_range(0, 3) == 0);

        // B: fixed-delay gating
        do_reset();
        b_ri = 1;
        for (int w = 0; w < 3; w++) begin
            b_v = 1; b_d = 16'h100 + 16'(w);
            @(posedge clk); #1 b_v = 0;
            b_lat(lat);
            chk("b_lat", lat, 5);
            chk("b_data", b_do, 16'h100 + 16'(w));
            @(negedge clk);
            chk("b_empty", b_cnt, 0);
            chk("b_v_idle", b_vo, 0);
            repeat (3) @(negedge clk);
        end
        b_v = 1; b_d = 16'hA0A0;
        @(posedge clk); #1 b_d = 16'hB0B0;
        @(posedge clk); #1 b_v = 0;
        b_lat(lat);
        chk("b_lat_first", lat, 4);
        chk("b_data_first", b_do, 16'hA0A0);
        b_lat(lat);
        chk("b_lat_second", lat, 4);
        chk("b_data_second", b_do, 16'hB0B0);
        @(negedge clk);
        chk("b_drained", b_cnt, 0);
        chk("b_fail", b_fail, 0);

        // C: two channels fed identically, drained through random gates
        do_reset();
        sent = 0; diff = 0;
        for (int c = 0; c < 2; c++) begin
            qc[c].delete(); st[c] = 0; fr[c] = 1; pvo[c] = 0;
        end
        for (int cyc = 0; cyc < 20000; cyc++) begin
            if (sent == 100 && qc[0].size() == 0 && qc[1].size() == 0) break;
            if (c_vo[0] != c_vo[1]) diff++;
            for (int c = 0; c < 2; c++) begin
                chk("c_count", c_cnt[c*4 +: 4], qc[c].size());
                if (c_cnt[c*4 +: 4] == 0) begin
                    st[c] = 0; fr[c] = 1;
                end else if (!c_vo[c]) begin
                    st[c]++;
                end else begin
                    if (!pvo[c])
                        chk("c_gap", st[c] >= int'(fr[c]) &&
                            st[c] - int'(fr[c]) <= 15, 1);
                    st[c] = 0; fr[c] = 0;
                end
                pvo[c] = c_vo[c];
            end
            v = sent < 100 && $urandom_range(0, 1) == 1 &&
                qc[0].size() < 8 && qc[1].size() < 8;
            r = $urandom_range(0, 3) != 0;
            d = 16'($urandom);
            for (int c = 0; c < 2; c++) begin
                if (c_vo[c] && r) begin
                    chk("c_nonempty", qc[c].size() != 0, 1);
                    if (qc[c].size() != 0)
                        chk("c_data", c_do[c*16 +: 16], qc[c].pop_front());
                end
                if (v) qc[c].push_back(d);
            end
            if (v) sent++;
            c_v = {v, v}; c_d = {d, d}; c_ri = {r, r};
            @(negedge clk);
        end
        chk("c_all_sent", sent, 100);
        chk("c_drained", qc[0].size() + qc[1].size(), 0);
        chk("c_seeds_differ", diff > 0, 1);
        chk("c_no_fail", c_fail, 0);

        // C: pass waits for the last buffered word
        c_v = 0; c_ri = 0;
        c_v = 2'b01; c_d = 32'h5A5A;
        @(negedge clk);
        c_v = 0; c_done = 2'b11;
        repeat (20) @(negedge clk);
        chk("c_pass_held", c_pass, 0);
        chk("c_hold_count", c_cnt[3:0], 1);
        chk("c_offer", c_vo[0], 1);
        c_ri = 2'b01;
        @(negedge clk);
        chk("c_pass", c_pass, 1);
        chk("c_after_yumi", c_cnt, 0);
        rst_n = 0;
        @(posedge clk);
        @(negedge clk);
        chk("c_reset_pass", c_pass, 0);
        chk("c_reset_count", c_cnt, 0);
        rst_n = 1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
